// File: rtl/reglk_pkg.sv
// Shared types and defaults for the lock-bit register bank.
package reglk_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ARMING = 2'd1,
        DEBUG  = 2'd2,
        RELOCK = 2'd3
    } reglk_state_e;

    localparam int unsigned DEF_NUM_WORDS   = 6;
    localparam int unsigned DEF_WORD_W      = 32;
    localparam int unsigned DEF_UNLOCK_HOLD = 4;
    localparam int unsigned DEF_CNT_W       = 8;

    typedef logic [DEF_WORD_W-1:0] reglk_words_t [DEF_NUM_WORDS];

    // Bits needed to index n entries, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reglk_bank_if.sv
// Write handshake and read port of the lock-bit register bank.
interface reglk_bank_if #(
    parameter int unsigned AW     = 3,
    parameter int unsigned WORD_W = 32
);
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [AW-1:0]     wr_addr_i;
    logic [WORD_W-1:0] wr_data_i;
    logic [AW-1:0]     rd_addr_i;
    logic [WORD_W-1:0] rd_data_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, rd_addr_i,
        input  wr_ready_o, rd_data_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, rd_addr_i,
        output wr_ready_o, rd_data_o
    );
endinterface

// File: rtl/reglk_unlock_fsm.sv
// Debug unlock sequencer: arming hold counter, debug/relock states and sticky freeze.
module reglk_unlock_fsm
    import reglk_pkg::*;
#(
    parameter int unsigned UNLOCK_HOLD = DEF_UNLOCK_HOLD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic unlock_i,
    input  logic auth_i,
    input  logic freeze_i,
    output logic dbg_mode_o,
    output logic frozen_o,
    output logic wr_ready_o,
    output logic clear_all_c
);

    localparam int unsigned CW = clog2_min1(UNLOCK_HOLD + 1);

    reglk_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic          arm_ok_c;

    // A freeze request in the same cycle blocks the unlock request.
    always_comb begin
        arm_ok_c    = unlock_i & auth_i & ~frozen_o & ~freeze_i;
        clear_all_c = 1'b0;
        if (arm_ok_c) begin
            if ((state_q == NORMAL) && (UNLOCK_HOLD == 32'd1)) begin
                clear_all_c = 1'b1;
            end
            if ((state_q == ARMING) && ((32'(cnt_q) + 32'd1) >= UNLOCK_HOLD)) begin
                clear_all_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= NORMAL;
            cnt_q      <= '0;
            frozen_o   <= 1'b0;
            wr_ready_o <= 1'b1;
            dbg_mode_o <= 1'b0;
        end else begin
            if (freeze_i && (state_q != DEBUG)) begin
                frozen_o <= 1'b1;
            end
            case (state_q)
                NORMAL: begin
                    if (clear_all_c) begin
                        state_q    <= DEBUG;
                        dbg_mode_o <= 1'b1;
                    end else if (arm_ok_c) begin
                        state_q    <= ARMING;
                        cnt_q      <= CW'(1);
                        wr_ready_o <= 1'b0;
                    end
                end
                ARMING: begin
                    if (clear_all_c) begin
                        state_q    <= DEBUG;
                        cnt_q      <= '0;
                        wr_ready_o <= 1'b1;
                        dbg_mode_o <= 1'b1;
                    end else if (arm_ok_c) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        state_q    <= NORMAL;
                        cnt_q      <= '0;
                        wr_ready_o <= 1'b1;
                    end
                end
                DEBUG: begin
                    if (!unlock_i || !auth_i) begin
                        state_q    <= RELOCK;
                        wr_ready_o <= 1'b0;
                        dbg_mode_o <= 1'b0;
                    end
                end
                RELOCK: begin
                    state_q    <= NORMAL;
                    wr_ready_o <= 1'b1;
                end
                default: begin
                    state_q    <= NORMAL;
                    cnt_q      <= '0;
                    wr_ready_o <= 1'b1;
                    dbg_mode_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/reglk_bank.sv
// Lock-bit register bank: set-only lock words, debug overwrite, read port and violation counter.
module reglk_bank
    import reglk_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = DEF_NUM_WORDS,
    parameter int unsigned WORD_W      = DEF_WORD_W,
    parameter int unsigned UNLOCK_HOLD = DEF_UNLOCK_HOLD,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    reglk_bank_if.slave                 bus,
    input  logic                        jtag_unlock_i,
    input  logic                        jtag_auth_i,
    input  logic                        freeze_i,
    output logic [NUM_WORDS*WORD_W-1:0] reglk_o,
    output logic                        dbg_mode_o,
    output logic                        frozen_o,
    output logic                        wr_err_o,
    output logic [CNT_W-1:0]            viol_cnt_o
);

    localparam int unsigned AW = clog2_min1(NUM_WORDS);

    logic [WORD_W-1:0] words_q [NUM_WORDS];
    logic [WORD_W-1:0] rd_data_q;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;
    logic              clear_all_c;
    logic              wr_acc;
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_addr          = bus.wr_addr_i;
    assign rd_addr          = bus.rd_addr_i;
    assign wr_data          = bus.wr_data_i;
    assign bus.wr_ready_o   = wr_ready;
    assign bus.rd_data_o    = rd_data_q;
    assign wr_acc           = bus.wr_valid_i & wr_ready;
    assign wr_in_range      = 32'(wr_addr) < NUM_WORDS;
    assign rd_in_range      = 32'(rd_addr) < NUM_WORDS;

    reglk_unlock_fsm #(
        .UNLOCK_HOLD (UNLOCK_HOLD)
    ) u_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .unlock_i    (jtag_unlock_i),
        .auth_i      (jtag_auth_i),
        .freeze_i    (freeze_i),
        .dbg_mode_o  (dbg_mode_o),
        .frozen_o    (frozen_o),
        .wr_ready_o  (wr_ready),
        .clear_all_c (clear_all_c)
    );

    // Writes are only accepted in NORMAL or DEBUG, so dbg_mode_o selects the write semantics.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NUM_WORDS); k++) begin
                words_q[k] <= '0;
            end
            rd_data_q  <= '0;
            wr_err_o   <= 1'b0;
            viol_cnt_o <= '0;
        end else begin
            wr_err_o  <= wr_acc & (~wr_in_range | frozen_o);
            rd_data_q <= rd_in_range ? words_q[rd_addr] : '0;
            if (clear_all_c) begin
                for (int k = 0; k < int'(NUM_WORDS); k++) begin
                    words_q[k] <= '0;
                end
            end else if (wr_acc && wr_in_range && !frozen_o) begin
                if (dbg_mode_o) begin
                    words_q[wr_addr] <= wr_data;
                end else begin
                    words_q[wr_addr] <= words_q[wr_addr] | wr_data;
                    if ((|(words_q[wr_addr] & ~wr_data)) && (viol_cnt_o != '1)) begin
                        viol_cnt_o <= viol_cnt_o + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_WORDS); k++) begin : g_flat
        assign reglk_o[k*WORD_W +: WORD_W] = words_q[k];
    end

endmodule

// File: doc/reglk_bank.md
Name: reglk_bank

Overview:
- Parametrised lock-bit register bank holding NUM_WORDS x WORD_W lock bits that gate writes to protected registers across the SoC.
- Lock bits are set-only during normal operation, with no module-local reset.
- Lock bits are cleared only by the global reset or by an authenticated, held JTAG unlock sequence that enters a debug mode.
- An optional sticky freeze disables all further modification until the next global reset.

Parameters:
- NUM_WORDS, 6, number of lock words (>=1)
- WORD_W, 32, bits per lock word
- UNLOCK_HOLD, 4, consecutive cycles jtag_unlock_i and jtag_auth_i must both be high to enter DEBUG (>=1)
- CNT_W, 8, width of the violation counter
- AW, $clog2(NUM_WORDS) (min 1), address width, derived, not overridable

Ports:
- clk_i  in  1  single clock; everything is sampled on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted when wr_valid_i & wr_ready_o
- wr_addr_i  in  AW  target lock word
- wr_data_i  in  WORD_W  write data
- rd_addr_i  in  AW  read address
- rd_data_o  out  WORD_W  registered read data
- jtag_unlock_i  in  1  debug unlock request (level)
- jtag_auth_i  in  1  debug authentication status
- freeze_i  in  1  sets sticky freeze
- reglk_o  out  NUM_WORDS*WORD_W  all lock words, word k at bits [k*WORD_W +: WORD_W]
- dbg_mode_o  out  1  high while in DEBUG
- frozen_o  out  1  sticky freeze status
- wr_err_o  out  1  one-cycle pulse for a rejected or illegal write
- viol_cnt_o  out  CNT_W  saturating count of clear attempts in NORMAL

Behaviour:
- Reset (rst_i high, asynchronous): all lock words 0, state NORMAL, arming counter 0, frozen_o 0, viol_cnt_o 0, wr_err_o 0, rd_data_o 0, dbg_mode_o 0.
- No other input may clear the lock words except the ARMING->DEBUG transition.
- FSM states: NORMAL, ARMING, DEBUG, RELOCK.
- NORMAL:
  - wr_ready_o = 1.
  - Accepted in-range, unfrozen write: word <= word | wr_data_i (set-only).
  - If (word & ~wr_data_i) != 0, viol_cnt_o increments by 1, saturating at 2^CNT_W-1; the OR still applies.
  - If jtag_unlock_i & jtag_auth_i & ~frozen: go to ARMING with counter = 1.
- ARMING:
  - wr_ready_o = 0.
  - While both inputs stay high, counter increments. When counter == UNLOCK_HOLD, go to DEBUG and clear all lock words to 0 on that edge.
  - If either input drops, return to NORMAL; locks unchanged; counter cleared.
  - UNLOCK_HOLD = 1: enter DEBUG on the first edge the condition is seen and skip ARMING.
- DEBUG:
  - wr_ready_o = 1 and dbg_mode_o = 1.
  - Accepted in-range write overwrites the word (bits may be cleared).
  - When jtag_unlock_i is low or jtag_auth_i is low, go to RELOCK.
- RELOCK:
  - wr_ready_o = 0, one cycle, then NORMAL.
  - Lock words keep the values written during DEBUG.
- Freeze:
  - freeze_i high in any state other than DEBUG sets frozen_o on the next edge; it is cleared only by rst_i. freeze_i is ignored in DEBUG.
  - While frozen, writes are still accepted (ready follows state) but dropped, and the unlock request is ignored.
- Errors: wr_err_o pulses the cycle after an accepted write that is out of range (wr_addr_i >= NUM_WORDS) or frozen. Such writes do not modify state and do not count as violations.
- Latency:
  - A lock update is visible on reglk_o one cycle after the handshake.
  - rd_data_o presents the word at rd_addr_i one cycle after sampling and reflects the pre-write value if a write to the same word occurs in the same cycle.
  - An out-of-range read returns 0.
- Simultaneous events:
  - A write in the same cycle as NORMAL->ARMING is applied with NORMAL semantics.
  - freeze_i in the same cycle as NORMAL->ARMING: freeze wins, and the state stays NORMAL.
  - rst_i mid-ARMING or in DEBUG returns to NORMAL with all locks 0.

Decomposition:
- Package reglk_pkg holds:
  - the state enum reglk_state_e {NORMAL, ARMING, DEBUG, RELOCK};
  - localparam defaults for NUM_WORDS, WORD_W and UNLOCK_HOLD;
  - a typedef for the lock word array.
- Sub-module reglk_unlock_fsm contains the state register, arming counter and freeze flag. It outputs dbg_mode, clear_all (a pulse on entry to DEBUG) and wr_ready. The top level owns the storage, read path, error and violation logic.

Test Plan:
- Reset, then write word 2 = 0x0000_00F0, then word 2 = 0x0000_000F -> word 2 = 0x0000_00FF; viol_cnt_o = 1 (second write tried to clear 0xF0); wr_err_o stays 0.
- Set word 0 = 0xFFFF_FFFF; hold jtag_unlock_i and jtag_auth_i high for 3 cycles, then drop -> state returns to NORMAL, word 0 still 0xFFFF_FFFF. Hold both for 4 cycles -> all words 0 and dbg_mode_o = 1 on the 4th edge.
- In DEBUG, write word 1 = 0x1234_5678, then 0x0000_0001, then drop jtag_unlock_i -> word 1 = 0x0000_0001; one cycle with wr_ready_o = 0; then NORMAL, where word 1 is set-only again.
- Pulse freeze_i, write word 3 = 0xA5 -> word 3 unchanged; wr_err_o pulses once. Then hold unlock and auth high for 10 cycles -> dbg_mode_o stays 0.
- Write wr_addr_i = 6 with NUM_WORDS = 6 -> wr_err_o pulses; reglk_o unchanged. Read rd_addr_i = 6 -> rd_data_o = 0.
- Assert rst_i asynchronously mid-ARMING and mid-DEBUG -> all outputs at reset values immediately, without waiting for a clock edge. Separately, run 300 clear attempts with CNT_W = 8 -> viol_cnt_o saturates at 255.
